// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline interlock for load-use, redirect and data-memory stalls, with a wait timeout and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_reg_wb,
  input  logic        ex_redirect,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        pc_hold,
  output logic        if_id_hold,
  output logic        id_ex_hold,
  output logic        ex_mem_hold,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        mem_timeout,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, BAD = 2'd2, ERROR = 2'd3} state_t;
  localparam logic [7:0] LIMIT = 8'(TIMEOUT);
  state_t cur, nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic err, load_use, mem_stall, freeze;
  assign load_use = ex_is_load & ex_reg_wb & (ex_rd != 5'd0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  assign mem_stall = mem_req & ~mem_ack;
  // freeze: whole pipe held; the unused encoding behaves like ERROR
  assign freeze = (cur == RUN) ? mem_stall : (cur == MEM_WAIT) ? ~mem_ack : 1'b1;
  assign if_id_flush = ~freeze & ex_redirect;
  assign id_ex_bubble = ~freeze & (ex_redirect | load_use);
  assign pc_hold = freeze | (~ex_redirect & load_use);
  assign if_id_hold = pc_hold;
  assign id_ex_hold = freeze;
  assign ex_mem_hold = freeze;
  assign mem_timeout = err;
  assign state = cur;
  always_comb begin
    nxt = ERROR;
    wait_nxt = wait_cnt;
    if (cur == RUN) begin
      nxt = mem_stall ? MEM_WAIT : RUN;
      wait_nxt = mem_stall ? 8'd1 : 8'd0;
    end else if (cur == MEM_WAIT) begin
      nxt = mem_ack ? RUN : (wait_cnt == LIMIT) ? ERROR : MEM_WAIT;
      wait_nxt = mem_ack ? 8'd0 : wait_cnt + 8'd1;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur <= RUN;
      wait_cnt <= '0;
      err <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      cur <= nxt;
      wait_cnt <= wait_nxt;
      err <= err | (nxt == ERROR);
      if (pc_hold && ~&stall_cnt) stall_cnt <= stall_cnt + 16'd1;
      if (if_id_flush && ~&flush_cnt) flush_cnt <= flush_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed stimulus with a per-cycle behavioural model plus literal spot checks.
module tb_hazard_ctrl;
  localparam int TO = 4;
  logic clk = 1'b0, reset = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, ex_is_load = 0, ex_reg_wb = 0, ex_redirect = 0, mem_req = 0, mem_ack = 0;
  logic pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, if_id_flush, id_ex_bubble, mem_timeout;
  logic [1:0] state;
  logic [15:0] stall_cnt, flush_cnt;
  int errors = 0, checks = 0;

  hazard_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_reg_wb(ex_reg_wb),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ack(mem_ack), .pc_hold(pc_hold),
    .if_id_hold(if_id_hold), .id_ex_hold(id_ex_hold), .ex_mem_hold(ex_mem_hold),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .mem_timeout(mem_timeout),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // Model: mode 0 running, 1 waiting on memory, 3 dead until reset
  logic [1:0] m_mode = 0;
  int m_wait = 0, m_stall = 0, m_flush = 0;
  logic m_err = 0, lu, ms, e_freeze, e_flush, e_bub, e_pc;
  always @(negedge clk) begin
    if (!reset) begin
      m_mode = 0; m_wait = 0; m_err = 0; m_stall = 0; m_flush = 0;
    end
    lu = ex_is_load && ex_reg_wb && ex_rd != 0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    ms = mem_req && !mem_ack;
    e_freeze = (m_mode == 3) || (m_mode == 1 && !mem_ack) || (m_mode == 0 && ms);
    e_flush = !e_freeze && ex_redirect;
    e_bub = !e_freeze && (ex_redirect || lu);
    e_pc = e_freeze || (!e_freeze && !ex_redirect && lu);
    chk("ctrl", {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, if_id_flush, id_ex_bubble, mem_timeout, state},
        {e_pc, e_pc, e_freeze, e_freeze, e_flush, e_bub, m_err, m_mode});
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
    chk("exclusive", (id_ex_bubble & id_ex_hold) | (if_id_flush & if_id_hold), 0);
    if (reset) begin
      if (e_pc && m_stall < 65535) m_stall++;
      if (e_flush && m_flush < 65535) m_flush++;
      if (m_mode == 0 && ms) begin m_mode = 1; m_wait = 1; end
      else if (m_mode == 1) begin
        if (mem_ack) m_mode = 0;
        else if (m_wait == TO) begin m_mode = 3; m_err = 1; end
        else m_wait++;
      end
    end
  end

  task automatic settle(); @(negedge clk); #1; endtask
  task automatic adv(); @(posedge clk); #1; endtask
  task automatic clr();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_is_load = 0; ex_reg_wb = 0; ex_redirect = 0; mem_req = 0; mem_ack = 0;
  endtask
  task automatic do_reset(); clr(); reset = 0; settle(); adv(); reset = 1; endtask
  task automatic load_use5(); ex_is_load = 1; ex_reg_wb = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1; endtask

  initial begin
    settle();
    chk("rst_state", state, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_timeout", mem_timeout, 0);
    adv(); reset = 1;
    // load-use, then the bubble clears ex_rd
    load_use5(); settle();
    chk("lu_holds", {pc_hold, if_id_hold, id_ex_bubble, id_ex_hold}, 4'b1110);
    adv(); ex_rd = 0; settle();
    chk("lu_after", {pc_hold, if_id_hold, id_ex_bubble}, 0);
    chk("lu_stall", stall_cnt, 1);
    // ex_rd = 0 never stalls
    adv(); clr(); ex_is_load = 1; ex_reg_wb = 1; id_use_rs1 = 1; settle();
    chk("x0_none", {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, if_id_flush, id_ex_bubble}, 0);
    // redirect beats load-use
    adv(); do_reset();
    load_use5(); ex_redirect = 1; settle();
    chk("rd_lu", {if_id_flush, id_ex_bubble, pc_hold}, 3'b110);
    adv(); clr(); settle();
    chk("rd_flush", flush_cnt, 1);
    chk("rd_stall", stall_cnt, 0);
    // memory stall acked after three cycles
    adv(); do_reset();
    mem_req = 1; settle();
    chk("m1", {pc_hold, ex_mem_hold, state}, 4'b1100);
    adv(); settle(); chk("m2", {id_ex_hold, state}, 3'b101);
    adv(); settle(); chk("m3", {if_id_hold, state}, 3'b101);
    adv(); mem_ack = 1; settle(); chk("m_ack", {pc_hold, ex_mem_hold, state}, 4'b0001);
    adv(); clr(); settle();
    chk("m_run", state, 0);
    chk("m_stall", stall_cnt, 3);
    // ack cycle with redirect, then ack on the last permitted wait cycle
    adv(); mem_req = 1; adv(); ex_redirect = 1; mem_ack = 1; adv(); clr();
    mem_req = 1; repeat (4) adv(); mem_ack = 1; load_use5(); settle();
    chk("edge_ack", {state, mem_timeout, pc_hold, id_ex_bubble}, 5'b01011);
    adv(); clr(); settle(); chk("edge_run", state, 0);
    // timeout into ERROR
    adv(); mem_req = 1; repeat (5) adv(); settle();
    chk("err_state", {state, mem_timeout}, 3'b111);
    adv(); clr(); ex_redirect = 1; settle();
    chk("err_sticky", {mem_timeout, pc_hold, if_id_flush}, 3'b110);
    adv(); clr(); reset = 0; #1;
    chk("async_rst", {state, mem_timeout, pc_hold, id_ex_hold}, 0);
    chk("async_cnt", stall_cnt, 0);
    settle(); adv(); reset = 1;
    // saturation of stall_cnt
    load_use5();
    repeat (65537) adv();
    settle();
    chk("sat", stall_cnt, 16'hFFFF);
    adv(); clr(); settle();
    chk("sat_hold", stall_cnt, 16'hFFFF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
